// File: rtl/ov7725_pkg.sv
// Shared definitions for the OV7725 DVP capture path: FSM encoding,
// default frame geometry and RGB565 field helpers.
package ov7725_pkg;

    localparam logic [1:0] ST_WAIT_CFG = 2'd0;
    localparam logic [1:0] ST_SKIP     = 2'd1;
    localparam logic [1:0] ST_SYNC     = 2'd2;
    localparam logic [1:0] ST_ACTIVE   = 2'd3;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    function automatic logic [4:0] rgb565_r(input logic [15:0] px);
        return px[15:11];
    endfunction

    function automatic logic [5:0] rgb565_g(input logic [15:0] px);
        return px[10:5];
    endfunction

    function automatic logic [4:0] rgb565_b(input logic [15:0] px);
        return px[4:0];
    endfunction

endpackage

// File: rtl/ov7725_dvp_capture_edge.sv
// Registers the DVP sync inputs once and derives the VSYNC rise and
// HREF fall pulses used by the capture FSM.
module dvp_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    input  logic href,
    output logic vs_rise,
    output logic href_fall
);

    logic vsync_d_r;
    logic href_d_r;

    // One-cycle delay of the sync lines for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r <= 1'b0;
            href_d_r  <= 1'b0;
        end else begin
            vsync_d_r <= vsync;
            href_d_r  <= href;
        end
    end

    assign vs_rise   = vsync & ~vsync_d_r;
    assign href_fall = href_d_r & ~href;

endmodule

// File: rtl/ov7725_dvp_capture.sv
// DVP capture: waits for sensor config, drops settling frames, then packs
// byte pairs into RGB565 pixels with coordinates and frame/line checks.
module ov7725_dvp_capture
    import ov7725_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FRAME_SKIP = 10,
    parameter int CNT_W      = 10
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iConfig_Done,
    input  logic             iCMOS_VSYNC,
    input  logic             iCMOS_HREF,
    input  logic [7:0]       iCMOS_DATA,
    output logic [15:0]      oPIXEL_DATA,
    output logic             oPIXEL_VALID,
    output logic [CNT_W-1:0] oPIXEL_X,
    output logic [CNT_W-1:0] oPIXEL_Y,
    output logic             oFRAME_START,
    output logic             oFRAME_END,
    output logic             oCAPTURE_EN,
    output logic             oLINE_ERR,
    output logic             oFRAME_ERR
);

    // Counters carry one extra bit so overruns past the active size stay visible
    localparam logic [CNT_W:0]   H_MAX     = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   V_MAX     = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(FRAME_SKIP - 1);
    localparam logic [CNT_W:0]   CNT_ONE   = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] SKIP_ONE  = CNT_W'(1);

    logic             vs_rise_s;
    logic             href_fall_s;
    logic [1:0]       state_r;
    logic [1:0]       state_case_s;
    logic [1:0]       state_nx_s;
    logic [CNT_W-1:0] skip_cnt_r;
    logic             phase_r;
    logic [7:0]       hi_r;
    logic [CNT_W:0]   pix_cnt_r;
    logic [CNT_W:0]   line_cnt_r;
    logic             frame_start_s;
    logic             frame_end_s;
    logic             byte_s;
    logic             fall_s;
    logic             wrap_s;
    logic             bad_line_s;
    logic [CNT_W-1:0] x_sat_s;
    logic [CNT_W-1:0] y_sat_s;

    dvp_edge_detect u_edge (
        .clk       (iCLK),
        .rst_n     (iRST_N),
        .vsync     (iCMOS_VSYNC),
        .href      (iCMOS_HREF),
        .vs_rise   (vs_rise_s),
        .href_fall (href_fall_s)
    );

    // Next-state logic; dropping configuration always wins
    always_comb begin
        state_case_s = state_r;
        case (state_r)
            ST_WAIT_CFG: begin
                if (FRAME_SKIP == 0) begin
                    state_case_s = ST_SYNC;
                end else begin
                    state_case_s = ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (vs_rise_s && (skip_cnt_r == SKIP_LAST)) begin
                    state_case_s = ST_SYNC;
                end else begin
                    state_case_s = ST_SKIP;
                end
            end
            ST_SYNC: begin
                if (vs_rise_s) begin
                    state_case_s = ST_ACTIVE;
                end else begin
                    state_case_s = ST_SYNC;
                end
            end
            ST_ACTIVE: state_case_s = ST_ACTIVE;
            default:   state_case_s = ST_WAIT_CFG;
        endcase
        if (!iConfig_Done) begin
            state_nx_s = ST_WAIT_CFG;
        end else begin
            state_nx_s = state_case_s;
        end
    end

    // Qualified events and saturated coordinates for the datapath
    always_comb begin
        frame_start_s = iConfig_Done && vs_rise_s &&
                        ((state_r == ST_SYNC) || (state_r == ST_ACTIVE));
        frame_end_s   = iConfig_Done && vs_rise_s && (state_r == ST_ACTIVE);
        byte_s        = iConfig_Done && (state_r == ST_ACTIVE) && iCMOS_HREF && !vs_rise_s;
        fall_s        = iConfig_Done && (state_r == ST_ACTIVE) && href_fall_s && !vs_rise_s;
        wrap_s        = (pix_cnt_r >= H_MAX) || (line_cnt_r >= V_MAX);
        bad_line_s    = phase_r || (pix_cnt_r != H_MAX);
        if (pix_cnt_r >= H_MAX) begin
            x_sat_s = H_LAST;
        end else begin
            x_sat_s = pix_cnt_r[CNT_W-1:0];
        end
        if (line_cnt_r >= V_MAX) begin
            y_sat_s = V_LAST;
        end else begin
            y_sat_s = line_cnt_r[CNT_W-1:0];
        end
    end

    // State, counters, byte pairing and registered outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r      <= ST_WAIT_CFG;
            skip_cnt_r   <= '0;
            phase_r      <= 1'b0;
            hi_r         <= 8'h00;
            pix_cnt_r    <= '0;
            line_cnt_r   <= '0;
            oPIXEL_DATA  <= 16'h0000;
            oPIXEL_VALID <= 1'b0;
            oPIXEL_X     <= '0;
            oPIXEL_Y     <= '0;
            oFRAME_START <= 1'b0;
            oFRAME_END   <= 1'b0;
            oCAPTURE_EN  <= 1'b0;
            oLINE_ERR    <= 1'b0;
            oFRAME_ERR   <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            oCAPTURE_EN  <= (state_nx_s == ST_ACTIVE);
            oPIXEL_VALID <= 1'b0;
            oFRAME_START <= 1'b0;
            oFRAME_END   <= 1'b0;
            oFRAME_ERR   <= 1'b0;
            if (!iConfig_Done) begin
                skip_cnt_r <= '0;
                phase_r    <= 1'b0;
                pix_cnt_r  <= '0;
                line_cnt_r <= '0;
                oLINE_ERR  <= 1'b0;
            end else if (frame_start_s) begin
                oFRAME_START <= 1'b1;
                oFRAME_END   <= frame_end_s;
                oFRAME_ERR   <= frame_end_s && (line_cnt_r != V_MAX);
                phase_r      <= 1'b0;
                pix_cnt_r    <= '0;
                line_cnt_r   <= '0;
                oLINE_ERR    <= 1'b0;
            end else if ((state_r == ST_SKIP) && vs_rise_s) begin
                skip_cnt_r <= skip_cnt_r + SKIP_ONE;
            end else if (byte_s) begin
                phase_r <= ~phase_r;
                if (!phase_r) begin
                    hi_r <= iCMOS_DATA;
                end else begin
                    oPIXEL_DATA  <= {hi_r, iCMOS_DATA};
                    oPIXEL_VALID <= 1'b1;
                    oPIXEL_X     <= x_sat_s;
                    oPIXEL_Y     <= y_sat_s;
                    if (pix_cnt_r <= H_MAX) begin
                        pix_cnt_r <= pix_cnt_r + CNT_ONE;
                    end
                    if (wrap_s) begin
                        oLINE_ERR <= 1'b1;
                    end
                end
            end else if (fall_s) begin
                if (bad_line_s) begin
                    oLINE_ERR <= 1'b1;
                end
                phase_r   <= 1'b0;
                pix_cnt_r <= '0;
                if (line_cnt_r <= V_MAX) begin
                    line_cnt_r <= line_cnt_r + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7725_dvp_capture.sv
// Directed bench for ov7725_dvp_capture (H_ACTIVE=4, V_ACTIVE=2, FRAME_SKIP=2);
// expected pixels and frame pulses are queued and matched by a monitor.
module tb_ov7725_dvp_capture;

    localparam int CW = 10;

    typedef struct {
        logic [15:0] d;
        logic [9:0]  x;
        logic [9:0]  y;
        int          at;
    } pix_t;

    typedef struct {
        logic fs;
        logic fe;
        logic ferr;
        int   at;
    } evt_t;

    logic          clk;
    logic          rst_n;
    logic          cfg;
    logic          vs;
    logic          href;
    logic [7:0]    data;
    logic [15:0]   pix_data;
    logic          pix_valid;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          frame_start;
    logic          frame_end;
    logic          capture_en;
    logic          line_err;
    logic          frame_err;

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    pix_t pix_q[$];
    evt_t evt_q[$];
    logic [7:0] line_q[$];

    ov7725_dvp_capture #(
        .H_ACTIVE   (4),
        .V_ACTIVE   (2),
        .FRAME_SKIP (2),
        .CNT_W      (CW)
    ) dut (
        .iCLK         (clk),
        .iRST_N       (rst_n),
        .iConfig_Done (cfg),
        .iCMOS_VSYNC  (vs),
        .iCMOS_HREF   (href),
        .iCMOS_DATA   (data),
        .oPIXEL_DATA  (pix_data),
        .oPIXEL_VALID (pix_valid),
        .oPIXEL_X     (pix_x),
        .oPIXEL_Y     (pix_y),
        .oFRAME_START (frame_start),
        .oFRAME_END   (frame_end),
        .oCAPTURE_EN  (capture_en),
        .oLINE_ERR    (line_err),
        .oFRAME_ERR   (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic h, input logic [7:0] d);
        vs   = v;
        href = h;
        data = d;
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic vs_pulse(input logic fs, input logic fe, input logic ferr);
        evt_t e;
        if (fs || fe || ferr) begin
            e.fs = fs; e.fe = fe; e.ferr = ferr; e.at = edge_n + 1;
            evt_q.push_back(e);
        end
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    // Sends line_q as one HREF line; y is the expected (saturated) row
    task automatic send_line(input int y, input bit expect_pix);
        pix_t p;
        for (int i = 0; i < line_q.size(); i++) begin
            if (expect_pix && (i % 2 == 1)) begin
                p.d  = {line_q[i-1], line_q[i]};
                p.x  = ((i / 2) > 3) ? 10'd3 : 10'(i / 2);
                p.y  = 10'(y);
                p.at = edge_n + 1;
                pix_q.push_back(p);
            end
            step(1'b0, 1'b1, line_q[i]);
        end
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: match every strobe/pulse against the scoreboard queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                if (pix_q.size() == 0) begin
                    chk("pix_unexpected", {16'h0, pix_data}, 32'hFFFF_FFFF);
                end else begin
                    pix_t e;
                    e = pix_q.pop_front();
                    chk("pix_data", {16'h0, pix_data}, {16'h0, e.d});
                    chk("pix_x", {22'h0, pix_x}, {22'h0, e.x});
                    chk("pix_y", {22'h0, pix_y}, {22'h0, e.y});
                    chk("pix_cycle", edge_n, e.at);
                end
            end
            if (frame_start || frame_end || frame_err) begin
                if (evt_q.size() == 0) begin
                    chk("evt_unexpected", {29'h0, frame_start, frame_end, frame_err}, 32'h0);
                end else begin
                    evt_t e;
                    e = evt_q.pop_front();
                    chk("frame_pulses", {29'h0, frame_start, frame_end, frame_err},
                        {29'h0, e.fs, e.fe, e.ferr});
                    chk("frame_cycle", edge_n, e.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg = 1'b0; vs = 1'b0; href = 1'b0; data = 8'h00;
        #3;
        chk("rst_data", {16'h0, pix_data}, 32'h0);
        chk("rst_valid", {31'h0, pix_valid}, 32'h0);
        chk("rst_cap_en", {31'h0, capture_en}, 32'h0);
        chk("rst_line_err", {31'h0, line_err}, 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Config gating: VSYNC activity while unconfigured produces nothing
        vs_pulse(1'b0, 1'b0, 1'b0);
        vs_pulse(1'b0, 1'b0, 1'b0);
        line_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_line(0, 1'b0);
        cfg = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        vs_pulse(1'b0, 1'b0, 1'b0);
        vs_pulse(1'b0, 1'b0, 1'b0);
        chk("sync_cap_en", {31'h0, capture_en}, 32'h0);
        vs_pulse(1'b1, 1'b0, 1'b0);
        chk("active_cap_en", {31'h0, capture_en}, 32'h1);

        // Pixel assembly and a clean two-line frame
        line_q = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
        send_line(0, 1'b1);
        line_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        send_line(1, 1'b1);
        chk("clean_line_err", {31'h0, line_err}, 32'h0);
        vs_pulse(1'b1, 1'b1, 1'b0);

        // Short odd line, then a third line that overruns V_ACTIVE
        line_q = '{8'hC0, 8'hDE, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        send_line(0, 1'b1);
        line_q = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'hC1};
        send_line(1, 1'b1);
        chk("short_line_err", {31'h0, line_err}, 32'h1);
        line_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_line(1, 1'b1);
        chk("sticky_line_err", {31'h0, line_err}, 32'h1);
        vs_pulse(1'b1, 1'b1, 1'b1);
        chk("line_err_cleared", {31'h0, line_err}, 32'h0);

        // Three full lines: Y saturates and the frame is flagged
        line_q = '{8'h10, 8'h01, 8'h20, 8'h02, 8'h30, 8'h03, 8'h40, 8'h04};
        send_line(0, 1'b1);
        send_line(1, 1'b1);
        chk("two_lines_ok", {31'h0, line_err}, 32'h0);
        send_line(1, 1'b1);
        chk("third_line_err", {31'h0, line_err}, 32'h1);
        vs_pulse(1'b1, 1'b1, 1'b1);

        // One over-long line: X saturates at 3, frame too short
        line_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        send_line(0, 1'b1);
        chk("long_line_err", {31'h0, line_err}, 32'h1);
        vs_pulse(1'b1, 1'b1, 1'b1);

        // Deconfig after three bytes of a line
        line_q = '{8'hD1, 8'hD2};
        begin
            pix_t p;
            p.d = 16'hD1D2; p.x = 10'd0; p.y = 10'd0; p.at = edge_n + 2;
            pix_q.push_back(p);
        end
        step(1'b0, 1'b1, 8'hD1);
        step(1'b0, 1'b1, 8'hD2);
        step(1'b0, 1'b1, 8'hD3);
        cfg = 1'b0;
        step(1'b0, 1'b1, 8'hD4);
        chk("deconfig_cap_en", {31'h0, capture_en}, 32'h0);
        step(1'b0, 1'b1, 8'hD5);
        step(1'b0, 1'b1, 8'hD6);
        step(1'b0, 1'b0, 8'h00);
        vs_pulse(1'b0, 1'b0, 1'b0);

        // Reconfigure, capture one pixel, then reset asynchronously mid-cycle
        cfg = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        vs_pulse(1'b0, 1'b0, 1'b0);
        vs_pulse(1'b0, 1'b0, 1'b0);
        vs_pulse(1'b1, 1'b0, 1'b0);
        begin
            pix_t p;
            p.d = 16'h5AA5; p.x = 10'd0; p.y = 10'd0; p.at = edge_n + 2;
            pix_q.push_back(p);
        end
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'hA5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", {16'h0, pix_data}, 32'h0);
        chk("arst_valid", {31'h0, pix_valid}, 32'h0);
        chk("arst_cap_en", {31'h0, capture_en}, 32'h0);
        chk("arst_xy", {12'h0, pix_x, pix_y}, 32'h0);
        chk("arst_pulses", {28'h0, frame_start, frame_end, frame_err, line_err}, 32'h0);
        cfg = 1'b0;
        href = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        chk("pix_q_drained", pix_q.size(), 32'h0);
        chk("evt_q_drained", evt_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
